// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - M-extension multiply/divide unit, one bit per cycle
// Radix-2 shift-add multiply and restoring divide on magnitudes; signs applied in FIX.
module muldiv_sequencer #(
  parameter int data_width = 32,
  parameter int CNT_W      = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  flush,
  input  logic [2:0]            funct3,
  input  logic [data_width-1:0] operand_A,
  input  logic [data_width-1:0] operand_B,
  output logic [data_width-1:0] result,
  output logic                  done,
  output logic                  busy,
  output logic                  hold_pipeline
);

  localparam int W = data_width;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);
  localparam logic [W-1:0]     MIN_NEG  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]     ALL_ONES = {W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [2:0]       op_q;
  logic             neg_res_q;
  logic             neg_rem_q;
  logic [W-1:0]     addend_q;
  logic [2*W-1:0]   prod_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     result_q;

  logic         accept;
  logic         a_signed, b_signed;
  logic         sa, sb;
  logic [W-1:0] mag_a, mag_b;
  logic         is_div, div_zero, div_ovf, special;
  logic [W-1:0] special_res;

  assign accept = (state == S_IDLE) && start && !flush;
  assign is_div = funct3[2];

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (funct3)
      3'd1, 3'd4, 3'd6: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      3'd2:    a_signed = 1'b1;
      default: ;
    endcase
  end

  assign sa    = a_signed && operand_A[W-1];
  assign sb    = b_signed && operand_B[W-1];
  assign mag_a = sa ? -operand_A : operand_A;
  assign mag_b = sb ? -operand_B : operand_B;

  assign div_zero = is_div && (operand_B == '0);
  assign div_ovf  = is_div && !funct3[0] && (operand_A == MIN_NEG) && (operand_B == ALL_ONES);
  assign special  = div_zero || div_ovf;

  // Divide-by-zero takes priority; overflow quotient equals the dividend itself.
  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = funct3[1] ? operand_A : ALL_ONES;
    else if (div_ovf)
      special_res = funct3[1] ? '0 : operand_A;
  end

  // Multiply: {carry, hi} accumulates the addend when the low multiplier bit is set.
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  assign mul_sum  = {1'b0, prod_q[2*W-1:W]} + {1'b0, addend_q};
  assign mul_next = prod_q[0] ? {mul_sum, prod_q[W-1:1]} : {1'b0, prod_q[2*W-1:1]};

  // Divide: hi holds the partial remainder, lo shifts the dividend out and quotient in.
  logic [W:0]     div_shift, div_diff;
  logic [2*W-1:0] div_next;
  assign div_shift = {prod_q[2*W-1:W], prod_q[W-1]};
  assign div_diff  = div_shift - {1'b0, addend_q};
  assign div_next  = div_diff[W] ? {div_shift[W-1:0], prod_q[W-2:0], 1'b0}
                                 : {div_diff[W-1:0], prod_q[W-2:0], 1'b1};

  logic [2*W-1:0] mul_full;
  logic [W-1:0]   mul_out, quot, rem, div_out, fix_res;
  assign mul_full = neg_res_q ? -prod_q : prod_q;
  assign mul_out  = (op_q == 3'd0) ? mul_full[W-1:0] : mul_full[2*W-1:W];
  assign quot     = prod_q[W-1:0];
  assign rem      = prod_q[2*W-1:W];
  assign div_out  = op_q[1] ? (neg_rem_q ? -rem : rem) : (neg_res_q ? -quot : quot);
  assign fix_res  = op_q[2] ? div_out : mul_out;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = special ? S_DONE : S_CALC;
      S_CALC:  if (cnt_q == LAST_CNT) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      addend_q  <= '0;
      prod_q    <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q      <= funct3;
            neg_res_q <= sa ^ sb;
            neg_rem_q <= sa;
            cnt_q     <= '0;
            addend_q  <= is_div ? mag_b : mag_a;
            prod_q    <= {{W{1'b0}}, (is_div ? mag_a : mag_b)};
            if (special) result_q <= special_res;
          end
        end
        S_CALC: begin
          if (!flush) begin
            prod_q <= op_q[2] ? div_next : mul_next;
            cnt_q  <= cnt_q + 1'b1;
          end
        end
        S_FIX: begin
          if (!flush) result_q <= fix_res;
        end
        default: ;
      endcase
    end
  end

  assign result        = result_q;
  assign done          = (state == S_DONE);
  assign busy          = (state != S_IDLE);
  assign hold_pipeline = accept || (state == S_CALC) || (state == S_FIX);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed-vector bench for muldiv_sequencer
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] operand_A = '0;
  logic [31:0] operand_B = '0;
  logic [31:0] result;
  logic        done;
  logic        busy;
  logic        hold_pipeline;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic [7:0]  lat;
  } vec_t;

  muldiv_sequencer #(.data_width(32), .CNT_W(5)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .flush(flush),
    .funct3(funct3),
    .operand_A(operand_A),
    .operand_B(operand_B),
    .result(result),
    .done(done),
    .busy(busy),
    .hold_pipeline(hold_pipeline)
  );

  always #5 clk = ~clk;

  // Drives one op; lat counts edges from the accept edge to the done cycle (-1 on timeout).
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int hold_cnt);
    logic got;
    @(negedge clk);
    funct3 = f; operand_A = a; operand_B = b; start = 1'b1;
    #1;
    hold_cnt = hold_pipeline ? 1 : 0;
    lat = 0; got = 1'b0; res = '0;
    while (!got && lat < 100) begin
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
      if (done) begin
        got = 1'b1;
        res = result;
      end else if (hold_pipeline) hold_cnt++;
    end
    if (!got) lat = -1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    #1;
    vectors++;
    if (result !== 32'h0 || done !== 1'b0 || busy !== 1'b0 || hold_pipeline !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: result=%h done=%b busy=%b hold=%b, required 0/0/0/0",
               result, done, busy, hold_pipeline);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_table(input string name, input vec_t v[]);
    logic [31:0] res;
    int lat, hold_cnt, exp_hold;
    foreach (v[i]) begin
      run_op(v[i].f, v[i].a, v[i].b, res, lat, hold_cnt);
      exp_hold = (v[i].lat == 8'd34) ? 34 : 1;
      vectors++;
      if (res !== v[i].exp) begin
        miscompares++;
        $display("FAIL %s[%0d] result: got %h, required %h", name, i, res, v[i].exp);
      end
      vectors++;
      if (lat != int'(v[i].lat)) begin
        miscompares++;
        $display("FAIL %s[%0d] latency: got %0d, required %0d", name, i, lat, v[i].lat);
      end
      vectors++;
      if (hold_cnt != exp_hold) begin
        miscompares++;
        $display("FAIL %s[%0d] hold cycles: got %0d, required %0d", name, i, hold_cnt, exp_hold);
      end
    end
  endtask

  task automatic test_mul;
    vec_t v[];
    v = new[6];
    v[0] = '{3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 8'd34};
    v[1] = '{3'd1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 8'd34};
    v[2] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 8'd34};
    v[3] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 8'd34};
    v[4] = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 8'd34};
    v[5] = '{3'd0, 32'h12345678, 32'h00000000, 32'h00000000, 8'd34};
    run_table("mul", v);
  endtask

  task automatic test_div;
    vec_t v[];
    v = new[7];
    v[0] = '{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 8'd34};
    v[1] = '{3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 8'd34};
    v[2] = '{3'd5, 32'd100,      32'd7,        32'd14,       8'd34};
    v[3] = '{3'd7, 32'd100,      32'd7,        32'd2,        8'd34};
    v[4] = '{3'd4, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 8'd34};
    v[5] = '{3'd6, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 8'd34};
    v[6] = '{3'd5, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 8'd34};
    run_table("div", v);
  endtask

  task automatic test_special;
    vec_t v[];
    v = new[6];
    v[0] = '{3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 8'd1};
    v[1] = '{3'd6, 32'd5,        32'd0,        32'd5,        8'd1};
    v[2] = '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 8'd1};
    v[3] = '{3'd7, 32'h00001234, 32'd0,        32'h00001234, 8'd1};
    v[4] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 8'd1};
    v[5] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 8'd1};
    run_table("special", v);
  endtask

  task automatic test_flush;
    logic [31:0] res;
    int lat, hold_cnt, seen;
    run_op(3'd5, 32'd100, 32'd7, res, lat, hold_cnt);
    vectors++;
    if (res !== 32'd14) begin
      miscompares++;
      $display("FAIL flush_pre result: got %h, required %h", res, 32'd14);
    end
    // start together with flush in IDLE must not be accepted
    @(negedge clk);
    funct3 = 3'd5; operand_A = 32'd1000; operand_B = 32'd3; start = 1'b1; flush = 1'b1;
    #1;
    vectors++;
    if (hold_pipeline !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_idle hold: got %b, required 0", hold_pipeline);
    end
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_idle busy: got %b, required 0", busy);
    end
    flush = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    vectors++;
    if (hold_pipeline !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_calc busy/hold: got %b/%b, required 1/1", busy, hold_pipeline);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    vectors++;
    if (busy !== 1'b0 || hold_pipeline !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_kill busy/hold: got %b/%b, required 0/0", busy, hold_pipeline);
    end
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL flush_no_done: got %0d done cycles, required 0", seen);
    end
    vectors++;
    if (result !== 32'd14) begin
      miscompares++;
      $display("FAIL flush_result_held: got %h, required %h", result, 32'd14);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    @(negedge clk);
    funct3 = 3'd0; operand_A = 32'd9; operand_B = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (result !== 32'h0 || done !== 1'b0 || busy !== 1'b0 || hold_pipeline !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: result=%h done=%b busy=%b hold=%b, required 0/0/0/0",
               result, done, busy, hold_pipeline);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL reset_mid_quiet: got %0d active cycles, required 0", seen);
    end
  endtask

  task automatic test_back_to_back;
    int cnt;
    logic got;
    @(negedge clk);
    funct3 = 3'd5; operand_A = 32'd100; operand_B = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    // second op presented immediately while the first is busy
    funct3 = 3'd0; operand_A = 32'h00000007; operand_B = 32'hFFFFFFFD;
    cnt = 1; got = 1'b0;
    while (!got && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
      if (done) got = 1'b1;
    end
    vectors++;
    if (cnt != 34 || result !== 32'd14) begin
      miscompares++;
      $display("FAIL b2b_first: latency %0d result %h, required 34 %h", cnt, result, 32'd14);
    end
    vectors++;
    if (hold_pipeline !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_done_hold: got %b, required 0", hold_pipeline);
    end
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0 || hold_pipeline !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_idle_gap busy/hold: got %b/%b, required 0/1", busy, hold_pipeline);
    end
    @(posedge clk); #1;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_second_accept busy: got %b, required 1", busy);
    end
    cnt = 1; got = 1'b0;
    while (!got && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
      if (done) got = 1'b1;
    end
    vectors++;
    if (cnt != 34 || result !== 32'hFFFFFFEB) begin
      miscompares++;
      $display("FAIL b2b_second: latency %0d result %h, required 34 %h", cnt, result, 32'hFFFFFFEB);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_mul;
    test_div;
    test_special;
    test_flush;
    test_reset_mid;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
